core_if_branch_predict: RTL and testbench
=========================================

// Module: core_if_branch_predict
//
// PURPOSE
//   Fetch-stage dynamic branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
//   Predicts taken/target for the current fetch PC in the same cycle.
//   Trained one entry per cycle by the resolved outcome from the EX-stage branch judge (branch valid + taken).
//   Sits between the PC generator (IF) and EX. EX returns the prediction index carried down the pipe.
//
// PARAMETERS
//   ENTRIES   16   table depth; power of two, >= 2
//   IDX_W     $clog2(ENTRIES)   localparam (derived), index width
//   TAG_W     30-IDX_W          localparam (derived), tag = pc[31:IDX_W+2]
//
// PORTS
//   clk            in   1      clock; all state updates on rising edge
//   rst            in   1      synchronous reset, active-high
//   i_if_valid     in   1      fetch PC valid this cycle
//   i_if_pc        in   32     fetch PC (word aligned, bits[1:0]=0)
//   o_pred_taken   out  1      predicted taken
//   o_pred_target  out  32     predicted next PC
//   o_pred_idx     out  IDX_W  table index used; pipelined to EX unchanged
//   i_ex_upd       in   1      resolved conditional branch in EX this cycle
//   i_ex_pc        in   32     PC of resolved branch
//   i_ex_idx       in   IDX_W  o_pred_idx captured at that branch's fetch
//   i_ex_taken     in   1      actual outcome from branch judge
//   i_ex_target    in   32     actual branch target (pc+imm)
//
// BEHAVIOUR
//   - Entry = {valid, tag[TAG_W], tgt[29:0], cnt[1:0]}; cnt: 00 SNT, 01 WNT, 10 WT, 11 ST.
//   - Reset (clk edge with rst=1): all valid=0, all cnt=01, GHR=0. rst overrides a same-cycle i_ex_upd.
//   - Lookup (combinational, 0 latency): idx = pc[IDX_W+1:2] (^ GHR when enabled).
//     hit = valid[idx] && tag[idx]==pc[31:IDX_W+2].
//     o_pred_taken = i_if_valid & hit & cnt[1].
//     o_pred_target = o_pred_taken ? {tgt,2'b00} : i_if_pc+32'd4 (mod 2^32 wrap).
//     o_pred_idx = idx regardless of i_if_valid.
//   - Update (registered, visible on the next cycle's lookup), entry e = table[i_ex_idx]:
//     hit, taken:      cnt sat-inc (11 stays 11); tgt <= i_ex_target[31:2].
//     hit, not taken:  cnt sat-dec (00 stays 00); tgt unchanged.
//     miss, taken:     allocate/replace: valid=1, tag=i_ex_pc[31:IDX_W+2], tgt=i_ex_target[31:2], cnt=10.
//     miss, not taken: no change.
//   - Same-cycle lookup and update of the same index: lookup returns the pre-update contents (no bypass).
//   - i_ex_upd=0: table and GHR hold. i_if_valid has no effect on state.
//   - Write uses i_ex_idx, never a recomputed index from i_ex_pc.
//
// CONFIGURATION
//   CORE_BP_GHR_EN defined:
//     IDX_W-bit global history register GHR.
//     On each i_ex_upd: GHR <= {GHR[IDX_W-2:0], i_ex_taken}.
//     Lookup idx = pc[IDX_W+1:2] ^ GHR (gshare indexing). Tag is still pc[31:IDX_W+2].
//   CORE_BP_GHR_EN undefined:
//     No GHR flops; idx = pc[IDX_W+1:2]; ports unchanged.
//
// STRUCTURE
//   core_bp_pkg: bp_entry_t packed struct; CNT_SNT/WNT/WT/ST localparams;
//                function bp_index(pc, ghr).
//   Sub-module core_bp_sat_counter: combinational 2-bit saturating next-state (cnt, taken) -> cnt_nxt.
//   Table is flops in core_if_branch_predict (synchronous reset clears all entries in one cycle).
//
// TESTING (ENTRIES=16, macro off unless noted)
//   1. After reset, pc=0x100 valid -> o_pred_taken=0, o_pred_target=0x104, o_pred_idx=0.
//   2. upd pc=0x100 idx=0 taken tgt=0x200; next cycle lookup 0x100 -> taken=1, target=0x200.
//   3. From case 2 (cnt=10): upd taken, taken, not-taken, not-taken -> predictions after each: 1,1,1,0 (cnt 11,11,10,01).
//   4. Alias: 0x140 (idx 0, other tag) after case 2 -> taken=0, target=0x144.
//      Taken upd 0x140 tgt 0x300 replaces entry; 0x100 then misses.
//   5. Lookup 0x100 in the same cycle as a taken upd to idx 0 from reset -> taken=0 that cycle, 1 next cycle.
//      Also cover 0xFFFFFFFC miss -> target 0x00000000 (wrap).
//   6. rst=1 together with i_ex_upd=1 -> entry not written; all lookups miss afterwards.
//      Macro on: two taken upds then lookup 0x100 -> o_pred_idx=3.

Source files
------------

// File: rtl/core_bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Gshare indexing is enabled with CORE_BP_GHR_EN (see core_if_branch_predict).
package core_bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Tag width depends on table depth, so tags live in a separate array in the top.
    typedef struct packed {
        logic        valid;
        logic [29:0] tgt;
        logic [1:0]  cnt;
    } bp_entry_t;

    function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] ghr,
                                             input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return ((pc >> 2) ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/core_bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating taken/not-taken counter.
module core_bp_sat_counter
    import core_bp_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/core_if_branch_predict.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup at IF, one-entry update from EX.
// Define CORE_BP_GHR_EN to XOR a global history register into the lookup index (gshare).
module core_if_branch_predict
    import core_bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_if_valid,
    input  logic [31:0]                i_if_pc,
    output logic                       o_pred_taken,
    output logic [31:0]                o_pred_target,
    output logic [$clog2(ENTRIES)-1:0] o_pred_idx,
    input  logic                       i_ex_upd,
    input  logic [31:0]                i_ex_pc,
    input  logic [$clog2(ENTRIES)-1:0] i_ex_idx,
    input  logic                       i_ex_taken,
    input  logic [31:0]                i_ex_target
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    bp_entry_t        entry_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    bp_entry_t        entry_d;
    logic [TAG_W-1:0] tag_d;
    logic [IDX_W-1:0] ghr;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit;
    logic             ex_hit;
    logic [1:0]       cnt_nxt;
    logic             unused_bits;

`ifdef CORE_BP_GHR_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    // Truncating cast keeps the youngest IDX_W outcomes, also valid when IDX_W == 1.
    always_comb ghr_d = i_ex_upd ? IDX_W'({ghr_q, i_ex_taken}) : ghr_q;

    always_ff @(posedge clk) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end

    assign ghr = ghr_q;
`else
    assign ghr = '0;
`endif

    assign lk_idx = IDX_W'(bp_index(i_if_pc, 32'(ghr), IDX_W));
    assign lk_hit = entry_q[lk_idx].valid && (tag_q[lk_idx] == i_if_pc[31:IDX_W+2]);

    assign o_pred_idx    = lk_idx;
    assign o_pred_taken  = i_if_valid & lk_hit & entry_q[lk_idx].cnt[1];
    assign o_pred_target = o_pred_taken ? {entry_q[lk_idx].tgt, 2'b00} : i_if_pc + 32'd4;

    // Training trusts the index carried down the pipe, not one recomputed from i_ex_pc.
    assign ex_hit = entry_q[i_ex_idx].valid && (tag_q[i_ex_idx] == i_ex_pc[31:IDX_W+2]);

    core_bp_sat_counter u_sat_counter (
        .cnt_i   (entry_q[i_ex_idx].cnt),
        .taken_i (i_ex_taken),
        .cnt_o   (cnt_nxt)
    );

    always_comb begin
        entry_d = entry_q[i_ex_idx];
        tag_d   = tag_q[i_ex_idx];
        if (ex_hit) begin
            entry_d.cnt = cnt_nxt;
            if (i_ex_taken) entry_d.tgt = i_ex_target[31:2];
        end else if (i_ex_taken) begin
            entry_d.valid = 1'b1;
            entry_d.tgt   = i_ex_target[31:2];
            entry_d.cnt   = CNT_WT;
            tag_d         = i_ex_pc[31:IDX_W+2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= '{valid: 1'b0, tgt: 30'd0, cnt: CNT_WNT};
                tag_q[i]   <= '0;
            end
        end else if (i_ex_upd) begin
            entry_q[i_ex_idx] <= entry_d;
            tag_q[i_ex_idx]   <= tag_d;
        end
    end

    assign unused_bits = ^{i_ex_pc[IDX_W+1:0], i_ex_target[1:0]};

endmodule

// File: tb/tb_core_if_branch_predict.sv
// Self-checking bench for core_if_branch_predict: directed cases then random traffic vs a model.
module tb_core_if_branch_predict;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_if_valid;
    logic [31:0]      i_if_pc;
    logic             o_pred_taken;
    logic [31:0]      o_pred_target;
    logic [IDX_W-1:0] o_pred_idx;
    logic             i_ex_upd;
    logic [31:0]      i_ex_pc;
    logic [IDX_W-1:0] i_ex_idx;
    logic             i_ex_taken;
    logic [31:0]      i_ex_target;

    int total = 0;
    int bad   = 0;

    // Reference model: per-slot valid/tag/target and counter as a plain 0..3 integer.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int          m_ghr;

    core_if_branch_predict #(.ENTRIES(ENTRIES)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_if_valid    (i_if_valid),
        .i_if_pc       (i_if_pc),
        .o_pred_taken  (o_pred_taken),
        .o_pred_target (o_pred_target),
        .o_pred_idx    (o_pred_idx),
        .i_ex_upd      (i_ex_upd),
        .i_ex_pc       (i_ex_pc),
        .i_ex_idx      (i_ex_idx),
        .i_ex_taken    (i_ex_taken),
        .i_ex_target   (i_ex_target)
    );

    always #5 clk = ~clk;

    task automatic expect32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        int ix;
        ix = int'((pc >> 2) % ENTRIES);
`ifdef CORE_BP_GHR_EN
        ix = ix ^ m_ghr;
`endif
        return ix;
    endfunction

    task automatic check_lookup(input string tag);
        int          ix;
        bit          hit;
        bit          et;
        logic [31:0] etgt;
        ix   = m_idx(i_if_pc);
        hit  = m_valid[ix] && (m_tag[ix] == (i_if_pc >> 6));
        et   = i_if_valid && hit && (m_cnt[ix] >= 2);
        etgt = et ? m_tgt[ix] : i_if_pc + 32'd4;
        expect32({tag, "_taken"}, 32'(o_pred_taken), 32'(et));
        expect32({tag, "_target"}, o_pred_target, etgt);
        expect32({tag, "_idx"}, 32'(o_pred_idx), 32'(ix));
    endtask

    task automatic model_edge();
        int e;
        bit hit;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = 1;
            end
            m_ghr = 0;
        end else if (i_ex_upd) begin
            e   = int'(i_ex_idx);
            hit = m_valid[e] && (m_tag[e] == (i_ex_pc >> 6));
            if (i_ex_taken) begin
                if (hit) begin
                    if (m_cnt[e] < 3) m_cnt[e]++;
                end else begin
                    m_valid[e] = 1'b1;
                    m_tag[e]   = i_ex_pc >> 6;
                    m_cnt[e]   = 2;
                end
                m_tgt[e] = i_ex_target & ~32'h3;
            end else if (hit && m_cnt[e] > 0) begin
                m_cnt[e]--;
            end
            m_ghr = ((m_ghr << 1) | int'(i_ex_taken)) % ENTRIES;
        end
    endtask

    // Check combinational outputs mid-cycle, then advance model and DUT together.
    task automatic step(input string tag);
        @(negedge clk);
        check_lookup(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc);
        i_if_valid = v;
        i_if_pc    = pc;
    endtask

    task automatic set_ex(input logic u, input logic [31:0] pc, input int ix, input logic tk,
                          input logic [31:0] tgt);
        i_ex_upd    = u;
        i_ex_pc     = pc;
        i_ex_idx    = IDX_W'(ix);
        i_ex_taken  = tk;
        i_ex_target = tgt;
    endtask

    initial begin
        rst = 1'b1;
        set_if(1'b0, 32'h0);
        set_ex(1'b0, 32'h0, 0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;

        // Reset state
        set_if(1'b1, 32'h100);
        @(negedge clk);
        expect32("reset_taken", 32'(o_pred_taken), 32'h0);
        expect32("reset_target", o_pred_target, 32'h104);
        expect32("reset_idx", 32'(o_pred_idx), 32'h0);
        step("t1");

        // Allocate while looking up the same index: old contents visible this cycle
        set_ex(1'b1, 32'h100, 0, 1'b1, 32'h200);
        step("t2_same_cycle");
        set_ex(1'b0, 32'h0, 0, 1'b0, 32'h0);
`ifndef CORE_BP_GHR_EN
        @(negedge clk);
        expect32("alloc_taken", 32'(o_pred_taken), 32'h1);
        expect32("alloc_target", o_pred_target, 32'h200);
`endif
        step("t2_after");

        // Counter walk: T, T, NT, NT
        set_ex(1'b1, 32'h100, 0, 1'b1, 32'h200); step("t3_a");
        step("t3_b");
        set_ex(1'b1, 32'h100, 0, 1'b0, 32'h200); step("t3_c");
        step("t3_d");
        set_ex(1'b0, 32'h0, 0, 1'b0, 32'h0);     step("t3_e");

        // Re-train, then alias 0x140 onto slot 0 and replace it
        set_ex(1'b1, 32'h100, 0, 1'b1, 32'h200); step("t4_train");
        set_ex(1'b0, 32'h0, 0, 1'b0, 32'h0);
        set_if(1'b1, 32'h140);                   step("t4_alias");
        set_ex(1'b1, 32'h140, 0, 1'b1, 32'h300); step("t4_replace");
        set_ex(1'b0, 32'h0, 0, 1'b0, 32'h0);     step("t4_new");
        set_if(1'b1, 32'h100);                   step("t4_old_miss");
        set_if(1'b0, 32'h140);                   step("t4_invalid");

        // Address wrap on a miss
        set_if(1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        expect32("wrap_target", o_pred_target, 32'h0);
        step("t5_wrap");

        // Reset wins over a same-cycle update
        rst = 1'b1;
        set_ex(1'b1, 32'h100, 0, 1'b1, 32'h200);
        set_if(1'b1, 32'h100);
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;
        set_ex(1'b0, 32'h0, 0, 1'b0, 32'h0);
        step("t6_after_rst");
        set_if(1'b1, 32'h140);                   step("t6_other");

`ifdef CORE_BP_GHR_EN
        set_ex(1'b1, 32'h500, 5, 1'b1, 32'h600); step("ghr_a");
        step("ghr_b");
        set_ex(1'b0, 32'h0, 0, 1'b0, 32'h0);
        set_if(1'b1, 32'h100);
        @(negedge clk);
        expect32("ghr_idx", 32'(o_pred_idx), 32'h3);
        step("ghr_c");
`endif

        // Random traffic over a small PC space to get frequent hits and aliasing
        for (int n = 0; n < 800; n++) begin
            logic [31:0] pc_a;
            logic [31:0] pc_b;
            pc_a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
            pc_b = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 31) == 0) pc_a = pc_a | 32'hFFFF_F000;
            set_if(1'($urandom_range(0, 3) != 0), pc_a);
            set_ex(1'($urandom_range(0, 9) < 7), pc_b,
                   ($urandom_range(0, 1) != 0) ? m_idx(pc_b) : int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), $urandom);
            rst = 1'($urandom_range(0, 63) == 0);
            step("rnd");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
